nic_port_lookup: RTL and testbench

- Datapath stage directly downstream of the input arbiter.
- Accepts the arbitrated packet stream (module-header words first, then payload) and buffers it in a small input FIFO.
- Reads the IOQ module header, chooses the output port by NIC mapping (MAC port i <-> CPU port i), and rewrites the header's destination field.
- Forwards the packet to the output queues; drops malformed packets and counts forwarded and dropped packets.

---
 rtl/nic_port_lookup_if.sv | 30 +++
 rtl/nic_port_lookup.sv | 175 +++++++++++++++++
 tb/tb_nic_port_lookup.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nic_port_lookup_if.sv
// Stream bundle between the input arbiter, the port lookup stage and
// the output queues, plus the lookup stage's statistics counters.
interface nic_port_lookup_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;
  logic [CNT_WIDTH-1:0]  pkt_fwd_cnt;
  logic [CNT_WIDTH-1:0]  pkt_drop_cnt;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr,
    input  pkt_fwd_cnt, pkt_drop_cnt
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr,
    output pkt_fwd_cnt, pkt_drop_cnt
  );
endinterface

// File: rtl/nic_port_lookup.sv
// NIC output-port lookup: buffers the arbitrated stream, maps MAC i <-> CPU i,
// rewrites the IOQ destination field and drops malformed packets.
module nic_port_lookup #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_PORTS       = 4,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(8'hFF),
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_WIDTH       = 32
) (
  input logic clk,
  input logic reset,
  nic_port_lookup_if.slave io
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int PW    = FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;

  typedef enum logic [2:0] {
    IDLE, FWD_HDR, FWD_PAY, DROP_HDR, DROP_PAY
  } state_t;

  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [CTRL_WIDTH-1:0] mem_ctrl_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic                  out_wr_q, out_wr_d;
  logic [CNT_WIDTH-1:0]  fwd_cnt_q, fwd_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                  empty, full, nearly_full;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [15:0]           src;
  logic [3:0]            dst_bit;
  logic [15:0]           new_dst;
  logic                  hdr_ok;
  logic                  is_pay;

  // FIFO status and head-of-queue decode
  always_comb begin
    empty       = (cnt_q == '0);
    full        = (cnt_q == CW'(DEPTH));
    nearly_full = (cnt_q >= CW'(DEPTH - 1));
    push        = io.in_wr && !full;
    head_data   = mem_data_q[rd_ptr_q];
    head_ctrl   = mem_ctrl_q[rd_ptr_q];
    src         = head_data[31:16];
    hdr_ok      = (head_ctrl == IOQ_CTRL) &&
                  (src < 16'(2 * NUM_PORTS));
    // MAC i sits at 2i, CPU i at 2i+1: partner is src with bit 0 flipped
    dst_bit     = src[3:0] ^ 4'd1;
    new_dst     = 16'd1 << dst_bit;
    is_pay      = (head_ctrl == '0);
  end

  // Packet framing FSM: pop decision, output word and statistics
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    out_wr_d   = 1'b0;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (hdr_ok) begin
            if (io.out_rdy) begin
              pop               = 1'b1;
              out_wr_d          = 1'b1;
              out_data_d        = head_data;
              out_data_d[63:48] = new_dst;
              out_ctrl_d        = head_ctrl;
              state_d           = FWD_HDR;
            end
          end else begin
            // a payload-looking first word already opens the payload region
            pop     = 1'b1;
            state_d = is_pay ? DROP_PAY : DROP_HDR;
          end
        end
      end
      FWD_HDR, FWD_PAY: begin
        if (!empty && io.out_rdy) begin
          pop        = 1'b1;
          out_wr_d   = 1'b1;
          out_data_d = head_data;
          out_ctrl_d = head_ctrl;
          if (is_pay) begin
            state_d = FWD_PAY;
          end else if (state_q == FWD_PAY) begin
            fwd_cnt_d = fwd_cnt_q + 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DROP_HDR, DROP_PAY: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_pay) begin
            state_d = DROP_PAY;
          end else if (state_q == DROP_PAY) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  // FIFO storage; a write while full is discarded so stored words stay intact
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_ctrl_q[i] <= '0;
      end
    end else if (push) begin
      mem_data_q[wr_ptr_q] <= io.in_data;
      mem_ctrl_q[wr_ptr_q] <= io.in_ctrl;
    end
  end

  // State, pointers, registered outputs and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= 1'b0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_wr_q   <= out_wr_d;
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign io.in_rdy       = !nearly_full;
  assign io.out_data     = out_data_q;
  assign io.out_ctrl     = out_ctrl_q;
  assign io.out_wr       = out_wr_q;
  assign io.pkt_fwd_cnt  = fwd_cnt_q;
  assign io.pkt_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_nic_port_lookup.sv
// Bench for nic_port_lookup: table of lookup vectors plus hand sequences,
// with a scoreboard queue checked against every out_wr beat.
module tb_nic_port_lookup;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  nic_port_lookup_if #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .CNT_WIDTH(32)
  ) bus ();

  nic_port_lookup #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_PORTS(4),
    .IOQ_CTRL(8'hFF), .FIFO_DEPTH_BITS(2), .CNT_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } word_t;

  typedef struct {
    logic [15:0] src;
    logic [7:0]  fctrl;
    int          nmod;
    logic        drop;
    logic [15:0] dst;
  } vec_t;

  word_t sb[$];
  vec_t  tbl[12];
  logic  pat[4];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_first = -1;
  int wr_last = -1;
  int exp_fwd = 0;
  int exp_drop = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    word_t got;
    word_t exp;
    if (bus.out_wr === 1'b1) begin
      got = {bus.out_ctrl, bus.out_data};
      wr_cnt++;
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h want=none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL out_word got=%h want=%h", got, exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] c,
                           input logic [63:0] d);
    int g = 0;
    while (bus.in_rdy !== 1'b1 && g < 200) begin
      bus.in_wr = 1'b0;
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 200) begin
      total++;
      bad++;
      $display("FAIL in_rdy_wait got=0 want=1");
    end
    bus.in_wr   = 1'b1;
    bus.in_ctrl = c;
    bus.in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [15:0] src,
                          input logic [7:0]  fctrl,
                          input int          nmod,
                          input int          npay,
                          input logic        fwd,
                          input logic [15:0] exp_dst,
                          input logic [15:0] tag);
    logic [63:0] hdr;
    logic [63:0] w;
    int n;
    n = nmod + npay + 2;
    hdr = {tag * 16'h0101, 16'(8 * n), src, 16'(n)};
    push_word(fctrl, hdr);
    if (fwd) sb.push_back({fctrl, exp_dst, hdr[47:0]});
    for (int i = 0; i < nmod; i++) begin
      w = {tag, 32'h0, 16'(i)};
      push_word(8'h10, w);
      if (fwd) sb.push_back({8'h10, w});
    end
    for (int i = 0; i < npay; i++) begin
      w = {tag, 48'h0} | (64'hA1 + 64'(i));
      push_word(8'h00, w);
      if (fwd) sb.push_back({8'h00, w});
    end
    w = {tag, 48'h0} | 64'hEE;
    push_word(8'h80, w);
    if (fwd) sb.push_back({8'h80, w});
    bus.in_wr = 1'b0;
    if (fwd) exp_fwd++;
    else exp_drop++;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_fwd_cnt"}, 64'(bus.pkt_fwd_cnt), 64'(exp_fwd));
    check({tag, "_drop_cnt"}, 64'(bus.pkt_drop_cnt), 64'(exp_drop));
  endtask

  initial begin
    logic [63:0] hdr;
    logic [63:0] w;

    tbl[0]  = '{16'd0,    8'hFF, 0, 1'b0, 16'h0002};
    tbl[1]  = '{16'd1,    8'hFF, 1, 1'b0, 16'h0001};
    tbl[2]  = '{16'd2,    8'hFF, 0, 1'b0, 16'h0008};
    tbl[3]  = '{16'd3,    8'hFF, 2, 1'b0, 16'h0004};
    tbl[4]  = '{16'd4,    8'hFF, 0, 1'b0, 16'h0020};
    tbl[5]  = '{16'd5,    8'hFF, 1, 1'b0, 16'h0010};
    tbl[6]  = '{16'd6,    8'hFF, 0, 1'b0, 16'h0080};
    tbl[7]  = '{16'd8,    8'hFF, 1, 1'b1, 16'h0000};
    tbl[8]  = '{16'd7,    8'h00, 0, 1'b1, 16'h0000};
    tbl[9]  = '{16'd7,    8'hFF, 0, 1'b0, 16'h0040};
    tbl[10] = '{16'hFFFF, 8'hFF, 0, 1'b1, 16'h0000};
    tbl[11] = '{16'd3,    8'h80, 1, 1'b1, 16'h0000};
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    pat[3] = 1'b1;

    bus.in_wr   = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    bus.out_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wr", 64'(bus.out_wr), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    check_cnts("rst");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single forwarded packet, MAC 0 -> CPU 0
    wr_cnt = 0;
    send_pkt(16'd0, 8'hFF, 0, 2, 1'b1, 16'h0002, 16'h0000);
    wait_drain();
    check("single_words", 64'(wr_cnt), 64'd4);
    check_cnts("single");

    // lookup and drop vectors
    for (int i = 0; i < 12; i++) begin
      int npay;
      npay = 1 + (i % 3);
      wr_cnt = 0;
      send_pkt(tbl[i].src, tbl[i].fctrl, tbl[i].nmod, npay,
               !tbl[i].drop, tbl[i].dst, 16'(i + 2));
      wait_drain();
      check($sformatf("vec%0d_words", i), 64'(wr_cnt),
            tbl[i].drop ? 64'd0 : 64'(tbl[i].nmod + npay + 2));
      check_cnts($sformatf("vec%0d", i));
    end

    // backpressure: 6-word packet with out_rdy pattern 1,0,0,1
    wr_cnt = 0;
    bus.out_rdy = 1'b0;
    fork
      send_pkt(16'd2, 8'hFF, 1, 3, 1'b1, 16'h0008, 16'h0030);
      begin
        repeat (5) @(posedge clk);
        #2;
        check("bp_in_rdy_low", 64'(bus.in_rdy), 64'd0);
        check("bp_stalled_words", 64'(wr_cnt), 64'd0);
        for (int k = 0; k < 16; k++) begin
          bus.out_rdy = pat[k % 4];
          @(posedge clk);
          #2;
        end
        bus.out_rdy = 1'b1;
      end
    join
    wait_drain();
    check("bp_words", 64'(wr_cnt), 64'd6);
    check_cnts("bp");

    // back-to-back packets with no gap and no bubble on the output
    wr_cnt = 0;
    wr_first = -1;
    send_pkt(16'd4, 8'hFF, 0, 1, 1'b1, 16'h0020, 16'h0040);
    send_pkt(16'd5, 8'hFF, 0, 1, 1'b1, 16'h0010, 16'h0041);
    wait_drain();
    check("b2b_words", 64'(wr_cnt), 64'd6);
    check("b2b_span", 64'(wr_last - wr_first), 64'd5);
    check_cnts("b2b");

    // asynchronous reset in the middle of a payload
    hdr = {16'h0000, 16'd32, 16'd6, 16'd4};
    push_word(8'hFF, hdr);
    sb.push_back({8'hFF, 16'h0080, hdr[47:0]});
    w = 64'h51;
    push_word(8'h00, w);
    sb.push_back({8'h00, w});
    w = 64'h52;
    push_word(8'h00, w);
    sb.push_back({8'h00, w});
    bus.in_wr = 1'b0;
    check("pre_rst_out_wr", 64'(bus.out_wr), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_wr", 64'(bus.out_wr), 64'd0);
    check("arst_out_data", bus.out_data, 64'd0);
    check("arst_in_rdy", 64'(bus.in_rdy), 64'd1);
    sb.delete();
    exp_fwd = 0;
    exp_drop = 0;
    check_cnts("arst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    wr_cnt = 0;
    send_pkt(16'd6, 8'hFF, 1, 2, 1'b1, 16'h0080, 16'h0050);
    wait_drain();
    check("post_rst_words", 64'(wr_cnt), 64'd5);
    check_cnts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
